invaes_seq_ctrl: RTL and testbench
==================================

Name: invaes_seq_ctrl

Overview:
Register-driven sequencer between the AXI4-Lite slave register decode and the inverse-AES core of the invaes IP.
- Collects the 128-bit key and 128-bit ciphertext from 32-bit word writes.
- Launches the core with a single start pulse, waits for completion under a timeout, and captures the plaintext.
- Exposes status, sticky error flags and an interrupt to software.

Parameters:
TIMEOUT_CYCLES, 1024, maximum WAIT-state cycles before the operation is abandoned (must be >= 2).
CNT_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter.

Ports:
ACLK  in  1  system clock; all logic on rising edge.
ARESETN  in  1  asynchronous active-low reset.
reg_wr_en  in  1  one-cycle word write strobe from the AXI-Lite decode.
reg_wr_idx  in  4  word index of the write.
reg_wr_data  in  32  write data.
reg_rd_idx  in  4  word index to read.
reg_rd_data  out  32  registered read data, valid 1 cycle after reg_rd_idx is presented.
core_start  out  1  one-cycle start pulse to the inverse-AES core.
core_key  out  128  key to the core; word 2 maps to [127:96].
core_ct  out  128  ciphertext to the core; word 6 maps to [127:96].
core_done  in  1  one-cycle completion pulse from the core.
core_pt  in  128  core plaintext, valid when core_done = 1.
irq  out  1  registered level interrupt.

Behaviour:
- Reset values: all outputs 0; every register 0; state IDLE; counter 0.
- Register map:
  - 0 CTRL: write bit0 START (self-clearing), bit1 IRQ_EN (stored), bit2 CLR (write-1, clears ERR and TIMEOUT). Reads return {30'b0, IRQ_EN, 1'b0}.
  - 1 STATUS (read-only): bit0 BUSY, bit1 DONE, bit2 ERR, bit3 TIMEOUT.
  - 2-5 KEY, MSW first, read/write.
  - 6-9 CT, MSW first, read/write.
  - 10-13 PT, MSW first, read-only.
  - 14-15 reserved; read 0, writes ignored.
- Writes to read-only or reserved words are ignored and do not set ERR.
- FSM states: IDLE, START, WAIT.
  - IDLE -> START: on a CTRL write with bit0 = 1. The same edge clears DONE and TIMEOUT.
  - START: core_start = 1 for exactly this cycle; counter cleared; always -> WAIT next cycle.
  - WAIT with core_done = 1: PT <= core_pt, DONE <= 1, -> IDLE.
  - WAIT with counter == TIMEOUT_CYCLES-1 and no core_done: TIMEOUT <= 1, PT unchanged, -> IDLE.
  - Otherwise in WAIT the counter increments.
  - core_done on the final counter cycle: done wins; TIMEOUT is not set.
- Latency: START write accepted at edge N; core_start high during cycle N+1; WAIT from N+2. DONE is visible in STATUS read data 2 cycles after the core_done edge (1 cycle to set, 1 cycle registered read).
- BUSY = (state != IDLE).
- ERR (sticky) is set by:
  - a START write while BUSY (the start is ignored);
  - a KEY or CT write while BUSY (the write is dropped).
- core_done outside WAIT is ignored; no state change and no ERR.
- Same write with both START and CLR: CLR is applied and the start launches. If that start is rejected because BUSY, the resulting ERR set wins over CLR.
- Any same-cycle set/clear of a sticky flag: set wins.
- Clearing DONE: DONE is cleared only by a new START. CLR does not affect DONE.
- irq <= IRQ_EN & (DONE | TIMEOUT), registered. It remains asserted until the cause clears or IRQ_EN = 0.
- core_key and core_ct are driven directly from the registers. They are stable throughout START/WAIT because writes are blocked while BUSY.
- Reset asserted mid-operation: immediate return to the reset values above. No core_start is issued until a new START write.

Decomposition:
- Package invaes_ctrl_pkg:
  - state enum (IDLE, START, WAIT);
  - word index localparams (IDX_CTRL, IDX_STATUS, IDX_KEY0, IDX_CT0, IDX_PT0);
  - CTRL and STATUS bit-position constants.
- One sub-module is natural: invaes_ctrl_regs. It holds the KEY/CT/PT storage, the write decode and the registered read mux. The FSM, timeout counter and sticky flags remain in the top module.

Test Plan:
- FIPS-197 vector:
  - Stimulus: write KEY 00010203_04050607_08090a0b_0c0d0e0f and CT 69c4e0d8_6a7b0430_d8cdb780_70b4c55a, then START. Bench core model returns core_done after 10 cycles.
  - Required: one core_start pulse; STATUS = 0x2; PT reads 00112233, 44556677, 8899aabb, ccddeeff.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 16; core model never asserts core_done.
  - Required: BUSY for exactly 1 + 16 cycles after START; STATUS = 0x8; PT still 0.
  - Then write CTRL = 0x4 -> STATUS = 0x0.
- Busy protection:
  - Stimulus: during WAIT, write KEY0 = 0xdeadbeef and START again.
  - Required: KEY0 unchanged; no second core_start; ERR = 1; the operation still completes with DONE = 1.
- Interrupt:
  - Stimulus: CTRL = 0x3 (IRQ_EN plus START).
  - Required: irq rises 1 cycle after DONE is set; writing CTRL = 0x0 drops irq the next cycle.
- Done at the timeout boundary:
  - Stimulus: core_done arrives on counter == TIMEOUT_CYCLES-1.
  - Required: STATUS = 0x2; TIMEOUT = 0; PT captured.
- Reset mid-WAIT:
  - Stimulus: deassert ARESETN for 3 cycles, then pulse core_done.
  - Required: all registers 0, irq 0, state IDLE; the late core_done is ignored.

Source files
------------

// File: rtl/invaes_ctrl_pkg.sv
// invaes sequencer shared types and constants.
// Word map, CTRL/STATUS bit positions and decode helpers.
package invaes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  localparam logic [3:0] IDX_CTRL   = 4'd0;
  localparam logic [3:0] IDX_STATUS = 4'd1;
  localparam logic [3:0] IDX_KEY0   = 4'd2;
  localparam logic [3:0] IDX_CT0    = 4'd6;
  localparam logic [3:0] IDX_PT0    = 4'd10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_TIMEOUT = 3;

  // True when idx falls in the 4-word block starting at base.
  function automatic logic in_blk(
    input logic [3:0] idx,
    input logic [3:0] base
  );
    logic [4:0] d;
    d = {1'b0, idx} - {1'b0, base};
    return d < 5'd4;
  endfunction

  // Lowest word index of a block holds the MSW.
  function automatic logic [1:0] word_sel(
    input logic [1:0] idx_lo,
    input logic [1:0] base_lo
  );
    logic [1:0] d;
    d = idx_lo - base_lo;
    return 2'd3 - d;
  endfunction

endpackage

// File: rtl/invaes_ctrl_regs.sv
// KEY/CT/PT storage, word write decode and registered read mux.
// Writes to KEY/CT are dropped while the sequencer is busy.
module invaes_ctrl_regs
  import invaes_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [31:0]  wr_data,
  input  logic         busy,
  input  logic         pt_load,
  input  logic [127:0] pt_in,
  input  logic [3:0]   rd_idx,
  input  logic [31:0]  ctrl_word,
  input  logic [31:0]  status_word,
  output logic [31:0]  rd_data,
  output logic [127:0] key,
  output logic [127:0] ct
);

  logic [3:0][31:0] key_q;
  logic [3:0][31:0] ct_q;
  logic [3:0][31:0] pt_q;
  logic [31:0]      rd_next;

  assign key = key_q;
  assign ct  = ct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      ct_q  <= '0;
      pt_q  <= '0;
    end else begin
      if (pt_load)
        pt_q <= pt_in;
      if (wr_en && !busy) begin
        if (in_blk(wr_idx, IDX_KEY0))
          key_q[word_sel(wr_idx[1:0], IDX_KEY0[1:0])] <= wr_data;
        if (in_blk(wr_idx, IDX_CT0))
          ct_q[word_sel(wr_idx[1:0], IDX_CT0[1:0])] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      rd_idx == IDX_CTRL:
        rd_next = ctrl_word;
      rd_idx == IDX_STATUS:
        rd_next = status_word;
      in_blk(rd_idx, IDX_KEY0):
        rd_next = key_q[word_sel(rd_idx[1:0], IDX_KEY0[1:0])];
      in_blk(rd_idx, IDX_CT0):
        rd_next = ct_q[word_sel(rd_idx[1:0], IDX_CT0[1:0])];
      in_blk(rd_idx, IDX_PT0):
        rd_next = pt_q[word_sel(rd_idx[1:0], IDX_PT0[1:0])];
      default:
        rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else
      rd_data <= rd_next;
  end

endmodule

// File: rtl/invaes_seq_ctrl.sv
// Sequencer between AXI-Lite register decode and inverse-AES core.
// Owns the FSM, timeout counter, sticky flags and interrupt.
module invaes_seq_ctrl
  import invaes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         reg_wr_en,
  input  logic [3:0]   reg_wr_idx,
  input  logic [31:0]  reg_wr_data,
  input  logic [3:0]   reg_rd_idx,
  output logic [31:0]  reg_rd_data,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_ct,
  input  logic         core_done,
  input  logic [127:0] core_pt,
  output logic         irq
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             irq_en;
  logic             done;
  logic             err;
  logic             timeout;

  logic        busy;
  logic        wr_ctrl;
  logic        start_req;
  logic        clr_req;
  logic        kc_wr;
  logic        launch;
  logic        pt_load;
  logic        tmo_hit;
  logic [31:0] ctrl_word;
  logic [31:0] status_word;

  assign busy      = state != IDLE;
  assign wr_ctrl   = reg_wr_en && reg_wr_idx == IDX_CTRL;
  assign start_req = wr_ctrl && reg_wr_data[CTRL_START];
  assign clr_req   = wr_ctrl && reg_wr_data[CTRL_CLR];
  assign kc_wr     = reg_wr_en &&
                     (in_blk(reg_wr_idx, IDX_KEY0) ||
                      in_blk(reg_wr_idx, IDX_CT0));
  assign launch    = start_req && !busy;
  assign pt_load   = state == WAIT && core_done;
  assign tmo_hit   = state == WAIT && !core_done && cnt == CNT_MAX;
  assign core_start = state == START;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (launch) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (pt_load || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: set takes priority over any same-edge clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      cnt     <= '0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state <= state_d;
      if (state == START)
        cnt <= '0;
      else if (state == WAIT && !core_done && !tmo_hit)
        cnt <= cnt + CNT_W'(1);
      if (wr_ctrl)
        irq_en <= reg_wr_data[CTRL_IRQ_EN];
      if (launch)
        done <= 1'b0;
      else if (pt_load)
        done <= 1'b1;
      if (tmo_hit)
        timeout <= 1'b1;
      else if (launch || clr_req)
        timeout <= 1'b0;
      if (busy && (start_req || kc_wr))
        err <= 1'b1;
      else if (clr_req)
        err <= 1'b0;
      irq <= irq_en && (done || timeout);
    end
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_IRQ_EN] = irq_en;
    status_word = '0;
    status_word[ST_BUSY]    = busy;
    status_word[ST_DONE]    = done;
    status_word[ST_ERR]     = err;
    status_word[ST_TIMEOUT] = timeout;
  end

  invaes_ctrl_regs u_regs (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .wr_en       (reg_wr_en),
    .wr_idx      (reg_wr_idx),
    .wr_data     (reg_wr_data),
    .busy        (busy),
    .pt_load     (pt_load),
    .pt_in       (core_pt),
    .rd_idx      (reg_rd_idx),
    .ctrl_word   (ctrl_word),
    .status_word (status_word),
    .rd_data     (reg_rd_data),
    .key         (core_key),
    .ct          (core_ct)
  );

endmodule

// File: tb/tb_invaes_seq_ctrl.sv
// Directed bench for invaes_seq_ctrl with a hand-driven core model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_invaes_seq_ctrl;

  localparam int TO = 16;
  localparam logic [127:0] KEY =
    128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] CT =
    128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] PT =
    128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] PT2 =
    128'h0badf00d_11111111_22222222_33333333;
  localparam logic [127:0] PT3 =
    128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         reg_wr_en = 1'b0;
  logic [3:0]   reg_wr_idx = '0;
  logic [31:0]  reg_wr_data = '0;
  logic [3:0]   reg_rd_idx = '0;
  logic [31:0]  reg_rd_data;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_ct;
  logic         core_done = 1'b0;
  logic [127:0] core_pt = '0;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;
  int nstart = 0;

  invaes_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_idx  (reg_wr_idx),
    .reg_wr_data (reg_wr_data),
    .reg_rd_idx  (reg_rd_idx),
    .reg_rd_data (reg_rd_data),
    .core_start  (core_start),
    .core_key    (core_key),
    .core_ct     (core_ct),
    .core_done   (core_done),
    .core_pt     (core_pt),
    .irq         (irq)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK)
    if (core_start) nstart++;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] d);
    reg_wr_en   = 1'b1;
    reg_wr_idx  = idx;
    reg_wr_data = d;
    @(negedge ACLK);
    reg_wr_en   = 1'b0;
  endtask

  task automatic rdchk(
    input string       tag,
    input logic [3:0]  idx,
    input logic [31:0] exp
  );
    reg_rd_idx = idx;
    @(negedge ACLK);
    chk(tag, {96'b0, reg_rd_data}, {96'b0, exp});
  endtask

  task automatic core_pulse(input int dly, input logic [127:0] pt);
    repeat (dly) @(negedge ACLK);
    core_done = 1'b1;
    core_pt   = pt;
    @(negedge ACLK);
    core_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int nbusy;

    repeat (2) @(negedge ACLK);
    chk("rst_core_start", {127'b0, core_start}, 128'd0);
    chk("rst_irq", {127'b0, irq}, 128'd0);
    chk("rst_rd_data", {96'b0, reg_rd_data}, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    rdchk("rst_status", 4'd1, 32'h0);

    // timeout with a silent core
    s0 = nstart;
    reg_rd_idx = 4'd1;
    wr(4'd0, 32'h1);
    chk("to_core_start", {127'b0, core_start}, 128'd1);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (reg_rd_data[0]) nbusy++;
    end
    chk("to_busy_cycles", 128'(nbusy), 128'(1 + TO));
    chk("to_nstart", 128'(nstart - s0), 128'd1);
    rdchk("to_status", 4'd1, 32'h8);
    rdchk("to_pt0", 4'd10, 32'h0);
    wr(4'd0, 32'h4);
    rdchk("to_clr_status", 4'd1, 32'h0);

    // FIPS-197 vector
    for (int i = 0; i < 4; i++) begin
      wr(4'(2 + i), KEY[127 - 32*i -: 32]);
      wr(4'(6 + i), CT[127 - 32*i -: 32]);
    end
    chk("fips_core_key", core_key, KEY);
    chk("fips_core_ct", core_ct, CT);
    rdchk("fips_key1", 4'd3, 32'h04050607);
    s0 = nstart;
    wr(4'd0, 32'h1);
    core_pulse(10, PT);
    chk("fips_nstart", 128'(nstart - s0), 128'd1);
    rdchk("fips_status", 4'd1, 32'h2);
    rdchk("fips_pt0", 4'd10, 32'h00112233);
    rdchk("fips_pt1", 4'd11, 32'h44556677);
    rdchk("fips_pt2", 4'd12, 32'h8899aabb);
    rdchk("fips_pt3", 4'd13, 32'hccddeeff);
    rdchk("fips_rsvd", 4'd14, 32'h0);

    // busy protection
    s0 = nstart;
    wr(4'd0, 32'h1);
    wr(4'd2, 32'hdeadbeef);
    wr(4'd0, 32'h1);
    core_pulse(3, PT);
    chk("busy_nstart", 128'(nstart - s0), 128'd1);
    rdchk("busy_status", 4'd1, 32'h6);
    rdchk("busy_key0", 4'd2, 32'h00010203);
    wr(4'd0, 32'h4);
    rdchk("busy_clr_status", 4'd1, 32'h2);

    // interrupt
    wr(4'd0, 32'h3);
    chk("irq_after_start", {127'b0, irq}, 128'd0);
    core_pulse(5, PT2);
    chk("irq_done_edge", {127'b0, irq}, 128'd0);
    @(negedge ACLK);
    chk("irq_rise", {127'b0, irq}, 128'd1);
    rdchk("irq_ctrl_rd", 4'd0, 32'h2);
    rdchk("irq_pt3", 4'd13, 32'h33333333);
    wr(4'd0, 32'h0);
    chk("irq_hold", {127'b0, irq}, 128'd1);
    @(negedge ACLK);
    chk("irq_drop", {127'b0, irq}, 128'd0);

    // done on the last counter cycle
    s0 = nstart;
    wr(4'd0, 32'h1);
    core_pulse(TO, PT3);
    rdchk("edge_status", 4'd1, 32'h2);
    rdchk("edge_pt0", 4'd10, 32'ha5a5a5a5);
    chk("edge_nstart", 128'(nstart - s0), 128'd1);

    // reset in the middle of WAIT
    wr(4'd0, 32'h3);
    repeat (4) @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    chk("mrst_core_start", {127'b0, core_start}, 128'd0);
    chk("mrst_irq", {127'b0, irq}, 128'd0);
    chk("mrst_rd_data", {96'b0, reg_rd_data}, 128'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    s0 = nstart;
    core_pulse(1, 128'hffffffff_ffffffff_ffffffff_ffffffff);
    rdchk("mrst_status", 4'd1, 32'h0);
    rdchk("mrst_ctrl", 4'd0, 32'h0);
    rdchk("mrst_key0", 4'd2, 32'h0);
    rdchk("mrst_ct0", 4'd6, 32'h0);
    rdchk("mrst_pt0", 4'd10, 32'h0);
    chk("mrst_core_key", core_key, 128'd0);
    chk("mrst_irq_late", {127'b0, irq}, 128'd0);
    chk("mrst_nstart", 128'(nstart - s0), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
